// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key-code map, {row,col} conversion, emulator state encoding, 100 MHz timing defaults.
// Pure declarations; no latency or flow control of its own.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;

  localparam int          CLK_HZ              = 100_000_000;
  localparam int          DEF_BOUNCE_CYCLES   = 500_000;
  localparam int          DEF_BOUNCE_TICK     = 5_000;
  localparam int          DEF_HOLD_CYCLES     = 3_000_000;
  localparam int          DEF_GAP_CYCLES      = 1_000_000;
  localparam logic [15:0] DEF_LFSR_SEED       = 16'hACE1;

  typedef logic [2:0] kp_state_t;
  localparam kp_state_t ST_IDLE       = 3'd0;
  localparam kp_state_t ST_BOUNCE_IN  = 3'd1;
  localparam kp_state_t ST_HOLD       = 3'd2;
  localparam kp_state_t ST_BOUNCE_OUT = 3'd3;
  localparam kp_state_t ST_GAP        = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Result is {row[1:0], col[1:0]}
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      KEY_1:   rc = 4'b00_00;
      KEY_2:   rc = 4'b00_01;
      KEY_3:   rc = 4'b00_10;
      KEY_A:   rc = 4'b00_11;
      KEY_4:   rc = 4'b01_00;
      KEY_5:   rc = 4'b01_01;
      KEY_6:   rc = 4'b01_10;
      KEY_B:   rc = 4'b01_11;
      KEY_7:   rc = 4'b10_00;
      KEY_8:   rc = 4'b10_01;
      KEY_9:   rc = 4'b10_10;
      KEY_C:   rc = 4'b10_11;
      KEY_E:   rc = 4'b11_00;
      KEY_0:   rc = 4'b11_01;
      KEY_F:   rc = 4'b11_10;
      default: rc = 4'b11_11;
    endcase
    return rc;
  endfunction

  function automatic logic [3:0] rc_to_key(input logic [3:0] rc);
    logic [3:0] code;
    case (rc)
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_E;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_F;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Keypad-side bundle: press command handshake, column drive in, row sense and status out.
// master = scanner/test side, slave = emulator; cmd_ready is the only backpressure.
interface keypad_emulator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_key;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       contact;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_key, cols,
    input  cmd_ready, rows, contact, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_key, cols,
    output cmd_ready, rows, contact, busy, done
  );
endinterface

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), seeded on reset, advances only while en_i is high.
// Latency: next_bit_o is the lsb of the value taken at the coming edge; no backpressure.
module bounce_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic next_bit_o
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign next_bit_o = lfsr_d[0];
endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: takes press commands, plays bounce/hold/bounce/gap, answers column drive on the rows.
// Latency: cols->rows is combinational; cmd_ready stays low from accept until the cycle after done.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
  parameter int          BOUNCE_TICK   = DEF_BOUNCE_TICK,
  parameter int          HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int          GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  keypad_emulator_if.slave  kp
);
  localparam int CW = $clog2(max3(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam int TW = $clog2(BOUNCE_TICK) + 1;
  localparam logic [CW-1:0] LD_BOUNCE = CW'(BOUNCE_CYCLES);
  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] LD_GAP    = CW'(GAP_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(BOUNCE_TICK - 1);
  localparam bit            NO_BOUNCE = (BOUNCE_CYCLES == 0);

  kp_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    row_q, row_d, col_q, col_d;
  logic          contact_q, contact_d;
  logic          phase_end, in_bounce, lfsr_en, lfsr_next_bit;

  assign phase_end = (cnt_q == CW'(1));
  assign in_bounce = (state_q == ST_BOUNCE_IN) || (state_q == ST_BOUNCE_OUT);
  assign lfsr_en   = in_bounce && (tick_q == TICK_LAST);

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i      (clk_i),
    .rst_n_i    (reset_n_i),
    .en_i       (lfsr_en),
    .next_bit_o (lfsr_next_bit)
  );

  always_comb begin
    state_d        = state_q;
    {row_d, col_d} = {row_q, col_q};
    case (state_q)
      ST_IDLE: begin
        if (kp.cmd_valid) begin
          state_d        = NO_BOUNCE ? ST_HOLD : ST_BOUNCE_IN;
          {row_d, col_d} = key_to_rc(kp.cmd_key);
        end
      end
      ST_BOUNCE_IN:  if (phase_end) state_d = ST_HOLD;
      ST_HOLD:       if (phase_end) state_d = NO_BOUNCE ? ST_GAP : ST_BOUNCE_OUT;
      ST_BOUNCE_OUT: if (phase_end) state_d = ST_GAP;
      ST_GAP:        if (phase_end) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // One shared down-counter: reloaded with the new phase length on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_BOUNCE_IN, ST_BOUNCE_OUT: cnt_d = LD_BOUNCE;
        ST_HOLD:                     cnt_d = LD_HOLD;
        ST_GAP:                      cnt_d = LD_GAP;
        default:                     cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    tick_d = tick_q + TW'(1);
    if (!in_bounce || (state_d != state_q) || lfsr_en) tick_d = '0;
  end

  // contact mirrors the LFSR lsb in bounce phases, so it is loaded from the value the LFSR is about to take.
  always_comb begin
    case (state_d)
      ST_BOUNCE_IN, ST_BOUNCE_OUT: contact_d = lfsr_next_bit;
      ST_HOLD:                     contact_d = 1'b1;
      default:                     contact_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tick_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      contact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      row_q     <= row_d;
      col_q     <= col_d;
      contact_q <= contact_d;
    end
  end

  assign kp.rows      = 4'b1111 & ~({3'b000, contact_q & ~kp.cols[col_q]} << row_q);
  assign kp.contact   = contact_q;
  assign kp.cmd_ready = (state_q == ST_IDLE);
  assign kp.busy      = (state_q != ST_IDLE);
  assign kp.done      = (state_q == ST_GAP) && phase_end;
endmodule

// File: tb/tb_keypad_emulator.sv
// Bench: one emulator without bounce and one with bounce, both checked cycle by cycle against a timeline model.
`timescale 1ns/1ps
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int          BC   = 20;
  localparam int          TICK = 3;
  localparam int          HC   = 50;
  localparam int          GC   = 10;
  localparam logic [15:0] SEED = 16'hACE1;
  // Keypad layout, index = row*4 + col
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_nb_n, rst_b_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] ref_lfsr;

  keypad_emulator_if kp_nb();
  keypad_emulator_if kp_b();

  keypad_emulator #(.BOUNCE_CYCLES(0), .BOUNCE_TICK(TICK), .HOLD_CYCLES(HC),
                    .GAP_CYCLES(GC), .LFSR_SEED(SEED))
    dut_nb (.clk_i(clk), .reset_n_i(rst_nb_n), .kp(kp_nb));

  keypad_emulator #(.BOUNCE_CYCLES(BC), .BOUNCE_TICK(TICK), .HOLD_CYCLES(HC),
                    .GAP_CYCLES(GC), .LFSR_SEED(SEED))
    dut_b (.clk_i(clk), .reset_n_i(rst_b_n), .kp(kp_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ready, busy, done, contact, rows[3:0]}
  function automatic logic [7:0] obs(input int sel);
    if (sel == 0) return {kp_nb.cmd_ready, kp_nb.busy, kp_nb.done, kp_nb.contact, kp_nb.rows};
    return {kp_b.cmd_ready, kp_b.busy, kp_b.done, kp_b.contact, kp_b.rows};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] k, input logic [3:0] c);
    if (sel == 0) begin
      kp_nb.cmd_valid = v; kp_nb.cmd_key = k; kp_nb.cols = c;
    end else begin
      kp_b.cmd_valid = v; kp_b.cmd_key = k; kp_b.cols = c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Expected contact t cycles after the accepting edge, from the phase timeline.
  function automatic logic exp_contact(input int bc, input int t, input logic [15:0] base);
    logic [15:0] v;
    if (t < bc) begin
      v = lfsr_adv(base, t / TICK);
      return v[0];
    end
    if (t < bc + HC) return 1'b1;
    if (t < 2 * bc + HC) begin
      v = lfsr_adv(base, bc / TICK + (t - bc - HC) / TICK);
      return v[0];
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_rows(input logic [3:0] key, input logic c, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 16; i++)
      if (KEYMAP[i] == key && c && !cols[i % 4]) r[i / 4] = 1'b0;
    return r;
  endfunction

  task automatic wait_ready(input int sel, input string tag);
    logic [7:0] o;
    for (int i = 0; i < 300; i++) begin
      o = obs(sel);
      if (o[7]) return;
      step();
    end
    chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_press(input int sel, input logic [3:0] key, input logic [3:0] colv, input string tag);
    int          bc, total;
    logic [15:0] base;
    logic [7:0]  o;
    logic        ec;
    bc    = (sel == 0) ? 0 : BC;
    total = 2 * bc + HC + GC;
    base  = ref_lfsr;
    drive(sel, 1'b0, key, colv);
    wait_ready(sel, tag);
    drive(sel, 1'b1, key, colv);
    step();
    drive(sel, 1'b0, key, colv);
    for (int t = 0; t < total; t++) begin
      o  = obs(sel);
      ec = exp_contact(bc, t, base);
      chk({tag, "_contact"}, 32'(o[4]), 32'(ec));
      chk({tag, "_rows"}, 32'(o[3:0]), 32'(exp_rows(key, ec, colv)));
      chk({tag, "_busy"}, 32'(o[6]), 32'd1);
      chk({tag, "_ready"}, 32'(o[7]), 32'd0);
      chk({tag, "_done"}, 32'(o[5]), 32'(t == total - 1));
      if (sel == 1 && t == bc / 2) begin
        drive(sel, 1'b0, key, 4'hF);
        #1 o = obs(sel);
        chk({tag, "_rows_cols_idle"}, 32'(o[3:0]), 32'hF);
        drive(sel, 1'b0, key, colv);
        #1 o = obs(sel);
        chk({tag, "_rows_zero_lat"}, 32'(o[3:0]), 32'(exp_rows(key, ec, colv)));
      end
      step();
    end
    o = obs(sel);
    chk({tag, "_end_busy"}, 32'(o[6]), 32'd0);
    chk({tag, "_end_ready"}, 32'(o[7]), 32'd1);
    chk({tag, "_end_done"}, 32'(o[5]), 32'd0);
    if (sel == 1) ref_lfsr = lfsr_adv(ref_lfsr, 2 * (BC / TICK));
  endtask

  initial begin
    logic [7:0] o;
    logic [3:0] key, cv, ev;
    logic       prev_ready, v_before;
    int         acc, viol, pr, pc;
    int         acc_t[3];

    // Package key map against the layout table
    for (int i = 0; i < 16; i++) begin
      chk("pkg_key_to_rc", 32'(key_to_rc(KEYMAP[i])), 32'(((i / 4) << 2) | (i % 4)));
      chk("pkg_rc_to_key", 32'(rc_to_key(4'(i))), 32'(KEYMAP[i]));
    end

    // T1: reset with cmd_valid high
    rst_nb_n = 1'b1; rst_b_n = 1'b1;
    drive(0, 1'b1, 4'h1, 4'b1110);
    drive(1, 1'b1, 4'h1, 4'b1110);
    #2 rst_nb_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      chk("t1_rows", 32'(o[3:0]), 32'hF);
      chk("t1_ready", 32'(o[7]), 32'd1);
      chk("t1_busy", 32'(o[6]), 32'd0);
      chk("t1_contact", 32'(o[4]), 32'd0);
      chk("t1_done", 32'(o[5]), 32'd0);
    end
    drive(0, 1'b0, 4'h1, 4'b1110);
    drive(1, 1'b0, 4'h1, 4'b1110);
    rst_nb_n = 1'b1; rst_b_n = 1'b1;
    ref_lfsr = SEED;
    repeat (5) step();
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      chk("t1_idle_busy", 32'(o[6]), 32'd0);
      chk("t1_idle_rows", 32'(o[3:0]), 32'hF);
    end

    // T2: key 5, no bounce
    run_press(0, 4'h5, 4'b1101, "t2");

    // T3: every code during HOLD with a one-hot column sweep, decoded back through the layout
    for (int k = 0; k < 16; k++) begin
      key = 4'(k);
      pr = 0; pc = 0;
      for (int i = 0; i < 16; i++) if (KEYMAP[i] == key) begin pr = i / 4; pc = i % 4; end
      drive(0, 1'b0, key, 4'hF);
      wait_ready(0, "t3");
      drive(0, 1'b1, key, 4'hF);
      step();
      for (int c = 0; c < 4; c++) begin
        cv = ~(4'b0001 << c);
        drive(0, 1'b0, key, cv);
        #1 o = obs(0);
        ev = (c == pc) ? ~(4'b0001 << pr) : 4'hF;
        chk("t3_rows", 32'(o[3:0]), 32'(ev));
        for (int r = 0; r < 4; r++)
          if (!o[r]) chk("t3_decode", 32'(KEYMAP[r * 4 + c]), 32'(key));
        step();
      end
    end
    drive(0, 1'b0, 4'h0, 4'hF);
    wait_ready(0, "t3_end");

    // T4: bounce on key 1, then several columns low at once
    run_press(1, 4'h1, 4'b1110, "t4");
    run_press(1, 4'h9, 4'b0000, "t4_multi");

    // Randomized presses
    for (int i = 0; i < 4; i++)
      run_press(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd");

    // T5: cmd_valid held across three commands
    key = 4'($urandom_range(0, 15));
    drive(1, 1'b0, key, 4'b1011);
    wait_ready(1, "t5");
    drive(1, 1'b1, key, 4'b1011);
    acc = 0; viol = 0;
    o = obs(1);
    prev_ready = o[7];
    for (int cyc = 1; cyc <= 330; cyc++) begin
      v_before = kp_b.cmd_valid;
      step();
      o = obs(1);
      if (prev_ready && v_before) begin
        if (acc < 3) acc_t[acc] = cyc;
        acc++;
        if (acc == 3) drive(1, 1'b0, key, 4'b1011);
      end
      if (o[7] == o[6]) viol++;
      prev_ready = o[7];
    end
    chk("t5_accepts", 32'(acc), 32'd3);
    chk("t5_spacing1", 32'(acc_t[1] - acc_t[0]), 32'(2 * BC + HC + GC + 1));
    chk("t5_spacing2", 32'(acc_t[2] - acc_t[1]), 32'(2 * BC + HC + GC + 1));
    chk("t5_ready_vs_busy", 32'(viol), 32'd0);
    ref_lfsr = lfsr_adv(ref_lfsr, 3 * 2 * (BC / TICK));
    run_press(1, 4'h6, 4'b1011, "t5_after");

    // T6: reset mid-HOLD releases the rows without a clock edge
    drive(0, 1'b0, 4'h5, 4'b1101);
    wait_ready(0, "t6");
    drive(0, 1'b1, 4'h5, 4'b1101);
    step();
    drive(0, 1'b0, 4'h5, 4'b1101);
    repeat (10) step();
    o = obs(0);
    chk("t6_hold_rows", 32'(o[3:0]), 32'b1101);
    #2 rst_nb_n = 1'b0;
    #1 o = obs(0);
    chk("t6_async_rows", 32'(o[3:0]), 32'hF);
    chk("t6_async_contact", 32'(o[4]), 32'd0);
    chk("t6_async_ready", 32'(o[7]), 32'd1);
    chk("t6_async_busy", 32'(o[6]), 32'd0);
    #2 rst_nb_n = 1'b1;
    step();
    run_press(0, 4'hA, 4'b0111, "t6_keyA");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
